// File: rtl/hcp_pkg.sv
// Shared constants and types for the HCP challenge-list emitter.
package hcp_pkg;

    localparam int HCP_ENTRY_W     = 5;
    localparam int HCP_NUM_ENTRIES = 4;
    localparam int HCP_ROUNDS      = 16;
    localparam int HCP_MASK_IDX_W  = $clog2(HCP_ROUNDS);
    localparam int HCP_POS_W       = $clog2(HCP_NUM_ENTRIES);
    localparam int HCP_LIST_W      = HCP_ENTRY_W * HCP_NUM_ENTRIES;

    typedef enum logic [1:0] {
        IDLE,
        EMIT,
        DONE
    } hcp_state_e;

    typedef logic [HCP_ENTRY_W-1:0] hcp_entry_t;

endpackage

// File: rtl/hcp_list_emitter_if.sv
// Job request, entry stream and result bundle of the HCP list emitter.
interface hcp_list_emitter_if;
    import hcp_pkg::*;

    logic                      LE_start;
    logic [HCP_LIST_W-1:0]     Lp;
    logic                      LE_end;
    logic                      out_valid;
    logic                      out_ready;
    hcp_entry_t                out_idx;
    logic [HCP_POS_W-1:0]      out_pos;
    logic [HCP_ROUNDS-1:0]     mask;
    logic                      err_range;
    logic                      err_dup;

    // master is the emitter; slave is the requester/consumer.
    modport master (
        input  LE_start, Lp, out_ready,
        output LE_end, out_valid, out_idx, out_pos, mask, err_range, err_dup
    );

    modport slave (
        output LE_start, Lp, out_ready,
        input  LE_end, out_valid, out_idx, out_pos, mask, err_range, err_dup
    );

endinterface

// File: rtl/hcp_entry_check.sv
// Per-entry range check, duplicate detect and mask update.
// Duplicate detection exists only when HCP_LIST_DUP_CHECK_EN is defined.
module hcp_entry_check
    import hcp_pkg::*;
(
    input  hcp_entry_t              entry,
    input  logic [HCP_ROUNDS-1:0]   mask_in,
    output logic                    in_range,
    output logic                    dup,
    output logic [HCP_ROUNDS-1:0]   mask_next
);

    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        in_range  = (entry < hcp_entry_t'(HCP_ROUNDS));
        mask_next = mask_in;
        dup       = 1'b0;
        if (in_range) begin
            mask_next[entry[HCP_MASK_IDX_W-1:0]] = 1'b1;
`ifdef HCP_LIST_DUP_CHECK_EN
            dup = mask_in[entry[HCP_MASK_IDX_W-1:0]];
`endif
        end
    end

endmodule

// File: rtl/hcp_list_emitter.sv
// Emits a captured 4-entry challenge list over a valid/ready stream and builds
// the round mask; duplicate flagging is built only with HCP_LIST_DUP_CHECK_EN.
module hcp_list_emitter
    import hcp_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    hcp_list_emitter_if.master   bus
);

    hcp_state_e               state;
    hcp_entry_t               entry [HCP_NUM_ENTRIES];
    logic [HCP_POS_W-1:0]     pos;
    logic                     le_end_q;
    logic                     out_valid_q;
    hcp_entry_t               out_idx_q;
    logic [HCP_POS_W-1:0]     out_pos_q;
    logic [HCP_ROUNDS-1:0]    mask_q;
    logic                     err_range_q;
    logic                     err_dup_q;

    logic                     in_range;
    logic                     dup;
    logic [HCP_ROUNDS-1:0]    mask_next;
    logic                     capture;

    // The entry being checked is always the one currently on the stream.
    hcp_entry_check u_check (
        .entry     (out_idx_q),
        .mask_in   (mask_q),
        .in_range  (in_range),
        .dup       (dup),
        .mask_next (mask_next)
    );

    assign capture = (state == IDLE) && bus.LE_start && !le_end_q;

    // NOTE: the list holding registers carry no reset; they are always reloaded before use.
    always_ff @(posedge clk) begin
        if (capture) begin
            for (int i = 0; i < HCP_NUM_ENTRIES; i++) begin
                entry[i] <= bus.Lp[(HCP_NUM_ENTRIES-1-i)*HCP_ENTRY_W +: HCP_ENTRY_W];
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state       <= IDLE;
            pos         <= '0;
            le_end_q    <= 1'b0;
            out_valid_q <= 1'b0;
            out_idx_q   <= '0;
            out_pos_q   <= '0;
            mask_q      <= '0;
            err_range_q <= 1'b0;
            err_dup_q   <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (capture) begin
                        pos         <= '0;
                        mask_q      <= '0;
                        err_range_q <= 1'b0;
                        err_dup_q   <= 1'b0;
                        state       <= EMIT;
                    end
                end
                EMIT: begin
                    if (!bus.LE_start) begin
                        state       <= IDLE;
                        out_valid_q <= 1'b0;
                        out_idx_q   <= '0;
                        out_pos_q   <= '0;
                        mask_q      <= '0;
                        err_range_q <= 1'b0;
                        err_dup_q   <= 1'b0;
                    end else if (!out_valid_q) begin
                        // First EMIT cycle presents entry 0 from the freshly captured list.
                        out_valid_q <= 1'b1;
                        out_idx_q   <= entry[pos];
                        out_pos_q   <= pos;
                    end else if (bus.out_ready) begin
                        mask_q      <= mask_next;
                        err_range_q <= err_range_q | ~in_range;
                        err_dup_q   <= err_dup_q | dup;
                        if (pos == HCP_POS_W'(HCP_NUM_ENTRIES - 1)) begin
                            out_valid_q <= 1'b0;
                            le_end_q    <= 1'b1;
                            state       <= DONE;
                        end else begin
                            pos       <= pos + 1'b1;
                            out_idx_q <= entry[pos + 1'b1];
                            out_pos_q <= pos + 1'b1;
                        end
                    end
                end
                DONE: begin
                    if (!bus.LE_start) begin
                        le_end_q <= 1'b0;
                        state    <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.LE_end    = le_end_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_idx   = out_idx_q;
    assign bus.out_pos   = out_pos_q;
    assign bus.mask      = mask_q;
    assign bus.err_range = err_range_q;
    assign bus.err_dup   = err_dup_q;

endmodule

// File: tb/tb_hcp_list_emitter.sv
// Scoreboard bench for hcp_list_emitter: stimulus pushes expected transfers and
// job results; a negedge monitor pops and compares them against the stream.
module tb_hcp_list_emitter;

    logic clk;
    logic reset;
    int   checks;
    int   failures;

`ifdef HCP_LIST_DUP_CHECK_EN
    localparam logic DUP_EN = 1'b1;
`else
    localparam logic DUP_EN = 1'b0;
`endif

    typedef struct {
        logic [4:0] idx;
        logic [1:0] pos;
    } xfer_t;

    typedef struct {
        logic [15:0] mask;
        logic        err_range;
        logic        err_dup;
    } done_t;

    xfer_t xfer_q[$];
    done_t done_q[$];

    hcp_list_emitter_if bus();

    hcp_list_emitter dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [19:0] lp4(input logic [4:0] e0, input logic [4:0] e1,
                                        input logic [4:0] e2, input logic [4:0] e3);
        return {e0, e1, e2, e3};
    endfunction

    // Queue the first n entries of a list as expected stream transfers.
    task automatic push_xfers(input logic [19:0] lp, input int n);
        xfer_t x;
        for (int i = 0; i < n; i++) begin
            x.idx = lp[(3-i)*5 +: 5];
            x.pos = 2'(i);
            xfer_q.push_back(x);
        end
    endtask

    task automatic push_done(input logic [15:0] mask, input logic er, input logic ed);
        done_t d;
        d.mask      = mask;
        d.err_range = er;
        d.err_dup   = ed;
        done_q.push_back(d);
    endtask

    // Counts edges after the start-sampling edge until LE_end rises; -1 on timeout.
    task automatic run_to_end(input int limit, output int n);
        n = -1;
        for (int i = 1; i <= limit; i++) begin
            tick();
            if (bus.LE_end) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_le_end"},    32'(bus.LE_end),    32'd0);
        check({tag, "_out_valid"}, 32'(bus.out_valid), 32'd0);
        check({tag, "_out_idx"},   32'(bus.out_idx),   32'd0);
        check({tag, "_out_pos"},   32'(bus.out_pos),   32'd0);
        check({tag, "_mask"},      32'(bus.mask),      32'd0);
        check({tag, "_err_range"}, 32'(bus.err_range), 32'd0);
        check({tag, "_err_dup"},   32'(bus.err_dup),   32'd0);
    endtask

    // Monitor: a transfer is an edge with valid & ready while running (not reset, not aborting).
    initial begin
        logic  le_end_prev;
        xfer_t x;
        done_t d;
        le_end_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (reset && bus.LE_start && bus.out_valid && bus.out_ready) begin
                if (xfer_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL xfer_unexpected: got idx=%0d pos=%0d expected no transfer",
                             bus.out_idx, bus.out_pos);
                end else begin
                    x = xfer_q.pop_front();
                    check("xfer_idx", 32'(bus.out_idx), 32'(x.idx));
                    check("xfer_pos", 32'(bus.out_pos), 32'(x.pos));
                end
            end
            if (bus.LE_end && !le_end_prev) begin
                if (done_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL le_end_unexpected: got LE_end=1 expected 0");
                end else begin
                    d = done_q.pop_front();
                    check("done_mask",      32'(bus.mask),      32'(d.mask));
                    check("done_err_range", 32'(bus.err_range), 32'(d.err_range));
                    check("done_err_dup",   32'(bus.err_dup),   32'(d.err_dup));
                    check("done_out_valid", 32'(bus.out_valid), 32'd0);
                end
            end
            le_end_prev = bus.LE_end;
        end
    end

    initial begin
        logic [19:0] lp;
        int          n;
        int          m;
        checks        = 0;
        failures      = 0;
        reset         = 1'b0;
        bus.LE_start  = 1'b0;
        bus.Lp        = '0;
        bus.out_ready = 1'b1;
        repeat (3) tick();
        check_reset_outputs("reset");
        reset = 1'b1;
        tick();

        // Basic list, ready always high.
        lp = lp4(5'd3, 5'd7, 5'd0, 5'd15);
        bus.Lp = lp;
        push_xfers(lp, 4);
        push_done(16'h8089, 1'b0, 1'b0);
        bus.LE_start = 1'b1;
        tick();
        run_to_end(20, n);
        check("basic_le_end_edge", 32'(n), 32'd5);
        check("basic_mask", 32'(bus.mask), 32'h8089);
        bus.LE_start = 1'b0;
        tick();
        check("basic_le_end_clear", 32'(bus.LE_end), 32'd0);

        // Out-of-range and repeated entries.
        lp = lp4(5'd5, 5'd20, 5'd5, 5'd1);
        bus.Lp = lp;
        push_xfers(lp, 4);
        push_done(16'h0022, 1'b1, DUP_EN);
        bus.LE_start = 1'b1;
        tick();
        run_to_end(20, n);
        check("errs_le_end_edge", 32'(n), 32'd5);
        bus.LE_start = 1'b0;
        tick();

        // Backpressure for three edges while pos=1 is presented.
        lp = lp4(5'd9, 5'd2, 5'd11, 5'd4);
        bus.Lp = lp;
        push_xfers(lp, 4);
        push_done(16'h0A14, 1'b0, 1'b0);
        bus.LE_start = 1'b1;
        tick();
        tick();
        tick();
        check("stall_pos_before", 32'(bus.out_pos), 32'd1);
        bus.out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("stall_idx_hold",   32'(bus.out_idx),   32'd2);
            check("stall_pos_hold",   32'(bus.out_pos),   32'd1);
            check("stall_valid_hold", 32'(bus.out_valid), 32'd1);
        end
        bus.out_ready = 1'b1;
        run_to_end(20, m);
        check("stall_le_end_edge", 32'(5 + m), 32'd8);
        bus.LE_start = 1'b0;
        tick();

        // Abort after two transfers, then restart the same list.
        lp = lp4(5'd6, 5'd1, 5'd8, 5'd12);
        bus.Lp = lp;
        push_xfers(lp, 2);
        bus.LE_start = 1'b1;
        repeat (4) tick();
        check("abort_mask_partial", 32'(bus.mask), 32'h0042);
        bus.LE_start = 1'b0;
        tick();
        check("abort_out_valid", 32'(bus.out_valid), 32'd0);
        check("abort_mask",      32'(bus.mask),      32'd0);
        check("abort_err_range", 32'(bus.err_range), 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("abort_le_end", 32'(bus.LE_end), 32'd0);
        end
        push_xfers(lp, 4);
        push_done(16'h1142, 1'b0, 1'b0);
        bus.LE_start = 1'b1;
        tick();
        run_to_end(20, n);
        check("restart_le_end_edge", 32'(n), 32'd5);
        bus.LE_start = 1'b0;
        tick();

        // Reset mid-EMIT at pos=2 with LE_start still high.
        lp = lp4(5'd10, 5'd3, 5'd14, 5'd2);
        bus.Lp = lp;
        push_xfers(lp, 2);
        bus.LE_start = 1'b1;
        repeat (4) tick();
        check("rst_pos_before", 32'(bus.out_pos), 32'd2);
        reset = 1'b0;
        #2;
        check("rst_no_async_valid", 32'(bus.out_valid), 32'd1);
        check("rst_no_async_idx",   32'(bus.out_idx),   32'd14);
        check("rst_no_async_pos",   32'(bus.out_pos),   32'd2);
        tick();
        check_reset_outputs("rst_mid");
        reset = 1'b1;
        bus.LE_start = 1'b0;
        tick();

        // LE_start held after completion must not start another job.
        lp = lp4(5'd1, 5'd2, 5'd3, 5'd4);
        bus.Lp = lp;
        push_xfers(lp, 4);
        push_done(16'h001E, 1'b0, 1'b0);
        bus.LE_start = 1'b1;
        tick();
        run_to_end(20, n);
        check("hold_le_end_edge", 32'(n), 32'd5);
        bus.Lp = lp4(5'd8, 5'd9, 5'd10, 5'd11);
        for (int i = 0; i < 10; i++) begin
            tick();
            check("hold_le_end",    32'(bus.LE_end),    32'd1);
            check("hold_out_valid", 32'(bus.out_valid), 32'd0);
        end
        check("hold_mask", 32'(bus.mask), 32'h001E);
        bus.LE_start = 1'b0;
        tick();
        check("hold_le_end_drop", 32'(bus.LE_end), 32'd0);

        // New job captures the new list; later Lp changes are ignored.
        lp = bus.Lp;
        push_xfers(lp, 4);
        push_done(16'h0F00, 1'b0, 1'b0);
        bus.LE_start = 1'b1;
        tick();
        bus.Lp = lp4(5'd31, 5'd31, 5'd31, 5'd31);
        run_to_end(20, n);
        check("newjob_le_end_edge", 32'(n), 32'd5);
        bus.LE_start = 1'b0;
        repeat (3) tick();

        check("xfer_q_empty", 32'(xfer_q.size()), 32'd0);
        check("done_q_empty", 32'(done_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/hcp_list_emitter.md
HCP_LIST_EMITTER -- requirements
Module: hcp_list_emitter

Interface
REQ-001 SHALL have port clk, input, 1, single clock; all logic on rising edge.
REQ-002 SHALL have port reset, input, 1, synchronous active-low reset, sampled only on the rising edge of clk.
REQ-003 SHALL have port LE_start, input, 1, level request; held high for the whole job, dropped after LE_end is seen.
REQ-004 SHALL have port Lp, input, 20, challenge list as four 5-bit entries {E0,E1,E2,E3}; E0=Lp[19:15], E3=Lp[4:0].
REQ-005 SHALL have port LE_end, output, 1, job complete; held high until LE_start drops.
REQ-006 SHALL have port out_valid, output, 1, out_idx and out_pos are valid.
REQ-007 SHALL have port out_ready, input, 1, downstream accepts the current entry.
REQ-008 SHALL have port out_idx, output, 5, current entry value.
REQ-009 SHALL have port out_pos, output, 2, current entry position, 0..3.
REQ-010 SHALL have port mask, output, 16, round-membership bitmask; bit k set when some accepted entry equals k.
REQ-011 SHALL have port err_range, output, 1, some entry was 16 or greater.
REQ-012 SHALL have port err_dup, output, 1, some entry repeated an earlier entry (see REQ-027).

Function
REQ-013 SHALL implement FSM states IDLE, EMIT and DONE; all outputs SHALL be registered.
REQ-014 SHALL, in IDLE with LE_start=1 and LE_end=0, capture Lp into four entry registers, clear pos, mask, err_range and err_dup, and go to EMIT.
REQ-015 SHALL, in EMIT, drive out_valid=1, out_idx=entry[pos] and out_pos=pos.
REQ-016 SHALL count a transfer on each edge with out_valid=1 and out_ready=1; with out_ready=0, outputs SHALL hold and nothing SHALL change.
REQ-017 SHALL, on each transfer of an entry below 16, set mask[entry].
REQ-018 SHALL, on each transfer of an entry of 16 or greater, set err_range and leave mask unchanged; the entry is still emitted.
REQ-019 SHALL, on each transfer, increment pos; the transfer at pos=3 SHALL move the FSM to DONE with out_valid=0 and LE_end=1.
REQ-020 SHALL, in DONE, hold mask, err_range and err_dup stable; LE_start=0 returns the FSM to IDLE with LE_end=0 on the next edge.
REQ-021 SHALL, with out_ready held at 1, assert LE_end exactly 5 edges after the edge that samples LE_start=1 in IDLE.
REQ-022 SHALL abort if LE_start drops during EMIT: next edge goes to IDLE with out_valid=0, mask=0, both error flags 0 and LE_end=0.
REQ-023 SHALL ignore Lp changes after capture.
REQ-024 SHALL NOT start a new job while LE_end=1, even if LE_start stays high.

Reset
REQ-025 SHALL, with reset=0 at a clock edge, go to IDLE and set LE_end=0, out_valid=0, out_idx=0, out_pos=0, mask=0, err_range=0, err_dup=0; reset SHALL take priority over every other event, including mid-EMIT.
REQ-026 SHALL NOT change state or outputs between clock edges in response to reset.

Configuration
REQ-027 SHALL provide macro HCP_LIST_DUP_CHECK_EN: when defined, a transfer of an entry below 16 whose mask bit is already set SHALL set err_dup; when undefined, err_dup SHALL be tied to 0 and no compare logic SHALL exist.

Structure
REQ-028 SHALL take from a shared package hcp_pkg: constants HCP_ENTRY_W=5, HCP_NUM_ENTRIES=4, HCP_ROUNDS=16, and the FSM state enum.
REQ-029 SHALL have one sub-module, hcp_entry_check (combinational: entry, current mask -> in_range, dup, next mask).

Verification
REQ-030 SHALL have a bench cover: Lp={3,7,0,15}, ready=1 -> out_idx 3,7,0,15 on pos 0..3; LE_end at edge +5; mask=0x8089; no errors.
REQ-031 SHALL have a bench cover: Lp={5,20,5,1}, macro on -> err_range=1, err_dup=1, mask=0x0022; macro off -> err_dup=0.
REQ-032 SHALL have a bench cover: ready low for 3 cycles at pos=1 -> out_idx/out_pos held; LE_end at edge +8.
REQ-033 SHALL have a bench cover: LE_start dropped after 2 transfers -> IDLE next edge; mask=0, LE_end never asserted; a restart re-emits from pos 0.
REQ-034 SHALL have a bench cover: reset=0 asserted at pos=2 -> all outputs at reset values after that edge; no change before the edge.
REQ-035 SHALL have a bench cover: LE_start held high 10 cycles after LE_end -> no second job; drop then raise -> new job captures the new Lp.
